// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS core's program-counter sequencer.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDRESS         = 32'h0;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  // Sign-extended branch immediate scaled to a byte displacement.
  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_pc_sequencer_if.sv
// Decode-to-sequencer bundle: redirect requests in, fetch PC and status out.
interface mips_cpu_pc_sequencer_if;

  // No valid/ready pair: redirect fields are level signals describing the
  // instruction at instr_address and are consumed only on a cycle where the
  // sequencer advances (clk_enable & ~stall & active); otherwise ignored.
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_target;

  logic [31:0] instr_address;
  logic        active;
  logic        delay_slot;
  logic        addr_error;

  modport master (
    output branch_taken, branch_offset, jump, jump_index, jump_reg, jump_reg_target,
    input  instr_address, active, delay_slot, addr_error
  );

  modport slave (
    input  branch_taken, branch_offset, jump, jump_index, jump_reg, jump_reg_target,
    output instr_address, active, delay_slot, addr_error
  );

endinterface

// File: rtl/mips_cpu_branch_target.sv
// Redirect target computation and priority select (jump_reg > jump > branch).
// MIPS_PC_ALIGN_CHECK_EN keeps misaligned low bits so the sequencer can trap.
module mips_cpu_branch_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] link,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] raw_target;

  assign link          = pc + INSTR_BYTES;
  assign branch_target = link + branch_disp(branch_offset);
  assign jump_target   = {link[31:28], jump_index, 2'b00};
  assign redirect      = branch_taken | jump | jump_reg;

  always_comb begin
    raw_target = branch_target;
    if (jump_reg) begin
      raw_target = jump_reg_target;
    end else if (jump) begin
      raw_target = jump_target;
    end
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  assign target = raw_target;
`else
  assign target = raw_target & ~32'h3;
`endif

endmodule

// File: rtl/mips_cpu_pc_sequencer.sv
// Program-counter sequencer with one-instruction delay slot and halt at PC 0.
// Optional feature macro: MIPS_PC_ALIGN_CHECK_EN (trap on misaligned target).
module mips_cpu_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    stall,
  mips_cpu_pc_sequencer_if.slave  seq_if,
  output pc_state_t               state_dbg
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] link;
  logic [31:0] target;
  logic        redirect;
  logic        active;
  logic        advance;
  logic        misaligned;

  mips_cpu_branch_target u_target (
    .pc              (pc_q),
    .branch_taken    (seq_if.branch_taken),
    .branch_offset   (seq_if.branch_offset),
    .jump            (seq_if.jump),
    .jump_index      (seq_if.jump_index),
    .jump_reg        (seq_if.jump_reg),
    .jump_reg_target (seq_if.jump_reg_target),
    .link            (link),
    .redirect        (redirect),
    .target          (target)
  );

  // Decoded straight from the registers so active drops with the PC reading 0.
  assign active  = (state_q != HALTED) && (pc_q != HALT_ADDRESS);
  assign advance = clk_enable & ~stall & active;

`ifdef MIPS_PC_ALIGN_CHECK_EN
  assign misaligned = (pending_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    if (advance) begin
      unique case (state_q)
        SEQ: begin
          pc_d = link;
          if (redirect) begin
            pending_d = target;
            state_d   = DELAY;
          end
        end
        DELAY: begin
          if (misaligned) begin
            state_d = HALTED;
          end else begin
            pc_d    = pending_q;
            state_d = SEQ;
          end
        end
        default: state_d = HALTED;
      endcase
      if (pc_d == HALT_ADDRESS) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEQ;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic addr_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_error_q <= 1'b0;
    end else if (advance && state_q == DELAY && misaligned) begin
      addr_error_q <= 1'b1;
    end
  end

  assign seq_if.addr_error = addr_error_q;
`else
  assign seq_if.addr_error = 1'b0;
`endif

  assign seq_if.instr_address = pc_q;
  assign seq_if.active        = active;
  assign seq_if.delay_slot    = (state_q == DELAY);
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// Scoreboard bench for mips_cpu_pc_sequencer: directed plan plus random redirects.
module tb_mips_cpu_pc_sequencer;
  import mips_cpu_pkg::*;

`ifdef MIPS_PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;
  logic stall = 1'b0;
  pc_state_t state_dbg;

  always #5 clk = ~clk;

  mips_cpu_pc_sequencer_if sif ();

  mips_cpu_pc_sequencer #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .stall      (stall),
    .seq_if     (sif),
    .state_dbg  (state_dbg)
  );

  // reference model: fetch PC, an optional pending redirect, halt/error flags
  logic [31:0] m_pc;
  logic        m_pend_valid;
  logic [31:0] m_pend;
  logic        m_halted;
  logic        m_err;

  // scoreboard: {pc, active, delay_slot, addr_error}
  logic [34:0] exp_q[$];
  int n_compared = 0;
  int n_mismatched = 0;

  function automatic void model_reset();
    m_pc = 32'hBFC00000;
    m_pend_valid = 1'b0;
    m_pend = 32'h0;
    m_halted = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] link;
    logic [31:0] tgt;
    logic signed [31:0] soff;
    if (m_halted || !clk_enable || stall) return;
    link = m_pc + 32'd4;
    if (m_pend_valid) begin
      m_pend_valid = 1'b0;
      if (ALIGN_CHECK && (m_pend % 4 != 0)) begin
        m_err = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = m_pend;
      end
    end else begin
      soff = $signed(sif.branch_offset);
      tgt = 32'h0;
      if (sif.jump_reg) tgt = sif.jump_reg_target;
      else if (sif.jump) tgt = (link & 32'hF0000000) + ({6'd0, sif.jump_index} * 4);
      else if (sif.branch_taken) tgt = link + soff * 4;
      if (!ALIGN_CHECK) tgt = tgt - (tgt % 4);
      if (sif.jump_reg || sif.jump || sif.branch_taken) begin
        m_pend_valid = 1'b1;
        m_pend = tgt;
      end
      m_pc = link;
    end
    if (m_pc == 32'h0) m_halted = 1'b1;
  endfunction

  function automatic void push_expected();
    exp_q.push_back({m_pc, ~m_halted, m_pend_valid & ~m_halted, m_err});
  endfunction

  // driver tasks
  task automatic idle_inputs();
    clk_enable = 1'b1;
    stall = 1'b0;
    sif.branch_taken = 1'b0;
    sif.branch_offset = 16'h0;
    sif.jump = 1'b0;
    sif.jump_index = 26'h0;
    sif.jump_reg = 1'b0;
    sif.jump_reg_target = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    push_expected();
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    push_expected();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_jump(input logic [25:0] idx);
    sif.jump = 1'b1;
    sif.jump_index = idx;
    cycle();
  endtask

  task automatic do_branch(input logic [15:0] off);
    sif.branch_taken = 1'b1;
    sif.branch_offset = off;
    cycle();
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    sif.jump_reg = 1'b1;
    sif.jump_reg_target = tgt;
    cycle();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // monitor: outputs are presented every cycle; compare one entry per negedge
  always @(negedge clk) begin
    logic [34:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instr_address", sif.instr_address, e[34:3]);
      check("active", {31'd0, sif.active}, {31'd0, e[2]});
      check("delay_slot", {31'd0, sif.delay_slot}, {31'd0, e[1]});
      check("addr_error", {31'd0, sif.addr_error}, {31'd0, e[0]});
    end
  end

  initial begin
    idle_inputs();
    do_reset();
    cycle();                    // BFC00004
    do_reset();

    do_jump(26'h3F00004);       // BFC00000 -> BFC00004 (slot)
    cycle();                    // -> BFC00010
    do_branch(16'hFFFD);        // -> BFC00014 (slot)
    cycle();                    // -> BFC00008
    do_jr(32'h0);               // -> BFC0000C (slot)
    cycle();                    // -> 0, halted
    for (int i = 0; i < 4; i++) begin
      stall = i[0];
      sif.jump = 1'b1;
      sif.jump_index = 26'h1234;
      cycle();
    end

    // stall and clock-enable gaps during DELAY
    do_reset();
    do_branch(16'h0010);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      sif.jump_reg = 1'b1;
      sif.jump_reg_target = 32'h1000;
      cycle();
    end
    clk_enable = 1'b0;
    cycle();
    cycle();                    // -> branch target

    // reset mid-DELAY
    do_jump(26'h0000040);
    do_reset();
    cycle();

    // priority: all three redirects at once, jump_reg wins
    sif.branch_taken = 1'b1;
    sif.branch_offset = 16'h0040;
    sif.jump = 1'b1;
    sif.jump_index = 26'h0000100;
    do_jr(32'hBFC00200);
    cycle();
    // jump beats branch
    sif.branch_taken = 1'b1;
    sif.branch_offset = 16'h0040;
    do_jump(26'h3F00300);
    cycle();

    // misaligned jump_reg target
    do_reset();
    do_jr(32'hBFC00022);
    cycle();
    cycle();
    cycle();

    // wrap from FFFFFFFC to 0 halts
    do_reset();
    do_jr(32'hFFFFFFF8);
    cycle();
    cycle();
    cycle();
    cycle();

    // randomized phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      int k;
      if (m_halted || $urandom_range(0, 59) == 0) do_reset();
      clk_enable = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      sif.branch_taken = (r == 1) || (r == 4) || (r == 5);
      sif.jump = (r == 2) || (r == 4) || (r == 6);
      sif.jump_reg = (r == 3) || (r == 4) || (r == 5);
      sif.branch_offset = 16'($urandom());
      sif.jump_index = 26'($urandom());
      k = $urandom_range(0, 9);
      if (k == 0) sif.jump_reg_target = 32'h0;
      else if (k == 1) sif.jump_reg_target = 32'hFFFFFFF8;
      else if (k == 2) sif.jump_reg_target = $urandom();
      else sif.jump_reg_target = {$urandom()} & 32'hFFFFFFFC;
      cycle();
    end

    // drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
